// File: rtl/scan_sequencer_if.sv
// Handshake/bus bundle between a scan controller client and scan_sequencer.
//   start, stop  : scan launch / synchronous abort requests
//   mode         : 0 = continuous scan, 1 = single sweep (latched on start)
//   mask         : slots to visit, sampled at every slot selection
//   blank, dwell : per-slot blanking and drive lengths in cycles
//   enable, sel  : decoder enable (1 = all outputs off) and decoder select
//   busy         : scan in progress
//   sweep_done   : one-cycle pulse when a single sweep completes
// master drives the requests, slave (the sequencer) drives the status.
interface scan_sequencer_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic             stop;
  logic             mode;
  logic [7:0]       mask;
  logic [3:0]       blank;
  logic [CNT_W-1:0] dwell;
  logic             enable;
  logic [2:0]       sel;
  logic             busy;
  logic             sweep_done;

  modport master (
    output start, stop, mode, mask, blank, dwell,
    input  enable, sel, busy, sweep_done
  );

  modport slave (
    input  start, stop, mode, mask, blank, dwell,
    output enable, sel, busy, sweep_done
  );
endinterface

// File: rtl/scan_sequencer.sv
// Timed scan controller for a 3-to-8 active-low decoder.
// Visits the set bits of mask in ascending order; each visited slot gets
// `blank` cycles with the decoder disabled followed by max(dwell,1) cycles
// with the decoder enabled. Continuous or single-sweep operation.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : scan_sequencer_if slave modport (requests in, decoder drive out)
module scan_sequencer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  scan_sequencer_if.slave  bus
);

  // Counter must hold both the 4-bit blank count and the dwell count.
  localparam int CW = (CNT_W > 4) ? CNT_W : 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          mode_q;
  logic          enable_q;
  logic [2:0]    sel_q;
  logic          done_q;
  logic [2:0]    next_sel;
  logic [2:0]    first_sel;
  logic          wrap;

  // First set bit searching cur+1, cur+2, ... modulo 8, with cur itself
  // examined last. Returns cur when mask is empty (caller guards that case).
  function automatic logic [2:0] next_slot(input logic [2:0] cur,
                                           input logic [7:0] m);
    logic [2:0] r;
    logic [2:0] idx;
    logic       found;
    r     = cur;
    found = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      idx = cur + 3'(i);
      if (!found && m[idx]) begin
        r     = idx;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  // A zero dwell still drives for one cycle.
  function automatic logic [CW-1:0] dwell_load(input logic [CNT_W-1:0] d);
    return (d == '0) ? CW'(1) : CW'(d);
  endfunction

  // Searching from slot 7 yields the lowest set bit of the mask.
  assign first_sel = next_slot(3'd7, bus.mask);
  assign next_sel  = next_slot(sel_q, bus.mask);
  assign wrap      = (next_sel <= sel_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      enable_q <= 1'b1;
      sel_q    <= 3'd0;
      cnt      <= '0;
      mode_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.stop) begin
        state    <= IDLE;
        enable_q <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            enable_q <= 1'b1;
            if (bus.start && (bus.mask != 8'd0)) begin
              mode_q <= bus.mode;
              sel_q  <= first_sel;
              if (bus.blank != 4'd0) begin
                state <= BLANK;
                cnt   <= CW'(bus.blank);
              end else begin
                state    <= DRIVE;
                cnt      <= dwell_load(bus.dwell);
                enable_q <= 1'b0;
              end
            end
          end

          BLANK: begin
            if (cnt <= CW'(1)) begin
              state    <= DRIVE;
              cnt      <= dwell_load(bus.dwell);
              enable_q <= 1'b0;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end

          DRIVE: begin
            if (cnt <= CW'(1)) begin
              // Slot advance.
              if (bus.mask == 8'd0) begin
                state    <= IDLE;
                enable_q <= 1'b1;
              end else if (wrap && mode_q) begin
                state    <= IDLE;
                enable_q <= 1'b1;
                done_q   <= 1'b1;
              end else begin
                sel_q <= next_sel;
                if (bus.blank != 4'd0) begin
                  state    <= BLANK;
                  cnt      <= CW'(bus.blank);
                  enable_q <= 1'b1;
                end else begin
                  state    <= DRIVE;
                  cnt      <= dwell_load(bus.dwell);
                  enable_q <= 1'b0;
                end
              end
            end else begin
              cnt <= cnt - CW'(1);
            end
          end

          default: begin
            state    <= IDLE;
            enable_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.enable     = enable_q;
  assign bus.sel        = sel_q;
  assign bus.busy       = (state != IDLE);
  assign bus.sweep_done = done_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Self-checking bench for scan_sequencer. The reference model describes a
// scan as a list of visited slots, each lasting blank + max(dwell,1) cycles,
// and predicts {sel, enable, busy, sweep_done} for every cycle after start.
module tb_scan_sequencer;

  logic clk = 1'b0;
  logic reset;

  scan_sequencer_if #(.CNT_W(8)) bus ();

  scan_sequencer #(.CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Observed samples, packed as {sel[2:0], enable, busy, sweep_done}.
  logic [5:0] obs [0:255];

  // Reference model state.
  int m_slots [0:7];
  int m_n;
  int m_b;
  int m_p;
  bit m_mode;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] sample();
    return {bus.sel, bus.enable, bus.busy, bus.sweep_done};
  endfunction

  task automatic set_model(input logic [7:0] m, input bit md, input int b, input int d);
    m_n = 0;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) begin
        m_slots[m_n] = i;
        m_n++;
      end
    end
    m_b    = b;
    m_p    = b + ((d == 0) ? 1 : d);
    m_mode = md;
  endtask

  // Expected outputs k cycles after the start edge.
  function automatic logic [5:0] model_at(input int k);
    int j;
    int r;
    logic [2:0] s;
    logic en, bs, dn;
    if (m_mode && k >= m_n * m_p) begin
      s  = 3'(m_slots[m_n-1]);
      en = 1'b1;
      bs = 1'b0;
      dn = (k == m_n * m_p);
    end else begin
      j  = (k / m_p) % m_n;
      r  = k % m_p;
      s  = 3'(m_slots[j]);
      en = (r < m_b);
      bs = 1'b1;
      dn = 1'b0;
    end
    return {s, en, bs, dn};
  endfunction

  // Present a start request with the given settings (sampled at next edge).
  task automatic launch(input logic [7:0] m, input bit md, input int b, input int d);
    bus.mask  = m;
    bus.mode  = md;
    bus.blank = 4'(b);
    bus.dwell = 8'(d);
    bus.start = 1'b1;
    set_model(m, md, b, d);
  endtask

  // Clock the start edge and record n cycles; with noise, start and mode
  // toggle randomly while the scan is busy.
  task automatic capture(input int n, input bit noise);
    step();
    bus.start = 1'b0;
    for (int k = 0; k < n; k++) begin
      obs[k] = sample();
      if (k < n - 1) begin
        if (noise && (!m_mode || k < m_n * m_p)) begin
          bus.start = 1'($urandom_range(1, 0));
          bus.mode  = 1'($urandom_range(1, 0));
        end else begin
          bus.start = 1'b0;
        end
        step();
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    logic [5:0] s;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.mode  = 1'b0;
    bus.mask  = 8'h00;
    bus.blank = 4'd0;
    bus.dwell = 8'd0;
    #2;
    s = sample();
    checks++;
    if (s !== 6'b000_1_0_0) begin
      errors++;
      $display("FAIL reset_state got sel|en|busy|done=%b expected %b", s, 6'b000_1_0_0);
    end
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_full_sweep();
    int nb;
    int nd;
    launch(8'hFF, 1'b1, 1, 2);
    capture(26, 1'b0);
    nb = 0;
    nd = 0;
    for (int k = 0; k < 26; k++) begin
      nb += int'(obs[k][1]);
      nd += int'(obs[k][0]);
      checks++;
      if (obs[k] !== model_at(k)) begin
        errors++;
        $display("FAIL full_sweep k=%0d got sel|en|busy|done=%b expected %b", k, obs[k], model_at(k));
      end
    end
    checks++;
    if (nb !== 24) begin
      errors++;
      $display("FAIL full_sweep_busy_len got %0d expected 24", nb);
    end
    checks++;
    if (nd !== 1) begin
      errors++;
      $display("FAIL full_sweep_done_count got %0d expected 1", nd);
    end
    step();
  endtask

  task automatic test_sparse_continuous();
    logic [5:0] s;
    launch(8'b1010_0100, 1'b0, 0, 3);
    capture(19, 1'b0);
    for (int k = 0; k < 19; k++) begin
      checks++;
      if (obs[k] !== model_at(k)) begin
        errors++;
        $display("FAIL sparse_cont k=%0d got sel|en|busy|done=%b expected %b", k, obs[k], model_at(k));
      end
    end
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    launch(8'b1010_0100, 1'b0, 0, 0);
    capture(7, 1'b0);
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (obs[k] !== model_at(k)) begin
        errors++;
        $display("FAIL dwell_zero k=%0d got sel|en|busy|done=%b expected %b", k, obs[k], model_at(k));
      end
    end
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    s = sample();
    checks++;
    if (s[2:0] !== 3'b100) begin
      errors++;
      $display("FAIL sparse_stop got en|busy|done=%b expected 100", s[2:0]);
    end
  endtask

  task automatic test_stop();
    logic [5:0] s;
    launch(8'hFF, 1'b1, 1, 2);
    // Slot 3 occupies cycles 9 (blank), 10 and 11 (dwell).
    capture(12, 1'b0);
    for (int k = 0; k < 12; k++) begin
      checks++;
      if (obs[k] !== model_at(k)) begin
        errors++;
        $display("FAIL stop_pre k=%0d got sel|en|busy|done=%b expected %b", k, obs[k], model_at(k));
      end
    end
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    s = sample();
    checks++;
    if (s !== 6'b011_1_0_0) begin
      errors++;
      $display("FAIL stop_drive got sel|en|busy|done=%b expected %b", s, 6'b011_1_0_0);
    end
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    step();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s = sample();
      checks++;
      if (s !== 6'b011_1_0_0) begin
        errors++;
        $display("FAIL start_stop_idle i=%0d got sel|en|busy|done=%b expected %b", i, s, 6'b011_1_0_0);
      end
      step();
    end
  endtask

  task automatic test_async_reset();
    logic [5:0] s;
    launch(8'b0110_0000, 1'b0, 5, 2);
    capture(3, 1'b0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs[k] !== model_at(k)) begin
        errors++;
        $display("FAIL areset_pre k=%0d got sel|en|busy|done=%b expected %b", k, obs[k], model_at(k));
      end
    end
    #3;
    reset = 1'b1;
    #1;
    s = sample();
    checks++;
    if (s !== 6'b000_1_0_0) begin
      errors++;
      $display("FAIL areset_mid_blank got sel|en|busy|done=%b expected %b", s, 6'b000_1_0_0);
    end
    #1;
    reset = 1'b0;
    step();
    launch(8'b0011_0000, 1'b1, 0, 1);
    capture(3, 1'b0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs[k] !== model_at(k)) begin
        errors++;
        $display("FAIL areset_post k=%0d got sel|en|busy|done=%b expected %b", k, obs[k], model_at(k));
      end
    end
    step();
  endtask

  task automatic test_mask_edges();
    logic [5:0] s;
    int b;
    int d;
    bus.mask  = 8'h00;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s = sample();
      checks++;
      if (s[2:0] !== 3'b100) begin
        errors++;
        $display("FAIL mask_zero_start i=%0d got en|busy|done=%b expected 100", i, s[2:0]);
      end
      step();
    end
    launch(8'h0C, 1'b0, 1, 2);
    capture(2, 1'b0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs[k] !== model_at(k)) begin
        errors++;
        $display("FAIL mask_clear_pre k=%0d got sel|en|busy|done=%b expected %b", k, obs[k], model_at(k));
      end
    end
    bus.mask = 8'h00;
    step();
    s = sample();
    checks++;
    if (s !== 6'b010_0_1_0) begin
      errors++;
      $display("FAIL mask_clear_drive got sel|en|busy|done=%b expected %b", s, 6'b010_0_1_0);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      s = sample();
      checks++;
      if (s !== 6'b010_1_0_0) begin
        errors++;
        $display("FAIL mask_clear_idle i=%0d got sel|en|busy|done=%b expected %b", i, s, 6'b010_1_0_0);
      end
    end
    b = $urandom_range(3, 0);
    d = $urandom_range(3, 0);
    launch(8'h80, 1'b1, b, d);
    capture(m_p + 2, 1'b0);
    for (int k = 0; k < m_p + 2; k++) begin
      checks++;
      if (obs[k] !== model_at(k)) begin
        errors++;
        $display("FAIL mask_80 k=%0d b=%0d d=%0d got sel|en|busy|done=%b expected %b", k, b, d, obs[k], model_at(k));
      end
    end
    step();
  endtask

  task automatic test_random_scan();
    logic [5:0] s;
    logic [7:0] m;
    int b;
    int d;
    int n;
    for (int it = 0; it < 4; it++) begin
      m = 8'($urandom_range(255, 1));
      b = $urandom_range(3, 0);
      d = $urandom_range(4, 0);
      launch(m, 1'b0, b, d);
      n = 2 * m_n * m_p + 3;
      capture(n, 1'b1);
      for (int k = 0; k < n; k++) begin
        checks++;
        if (obs[k] !== model_at(k)) begin
          errors++;
          $display("FAIL rand_cont it=%0d m=%h b=%0d d=%0d k=%0d got sel|en|busy|done=%b expected %b", it, m, b, d, k, obs[k], model_at(k));
        end
      end
      bus.stop = 1'b1;
      step();
      bus.stop = 1'b0;
      s = sample();
      checks++;
      if (s[2:0] !== 3'b100) begin
        errors++;
        $display("FAIL rand_cont_stop it=%0d got en|busy|done=%b expected 100", it, s[2:0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] m;
    int n;
    m = 8'($urandom_range(255, 1));
    launch(m, 1'b1, $urandom_range(2, 0), $urandom_range(3, 0));
    for (int it = 0; it < 3; it++) begin
      n = m_n * m_p + 1;
      capture(n, 1'b1);
      for (int k = 0; k < n; k++) begin
        checks++;
        if (obs[k] !== model_at(k)) begin
          errors++;
          $display("FAIL b2b it=%0d k=%0d got sel|en|busy|done=%b expected %b", it, k, obs[k], model_at(k));
        end
      end
      if (it < 2) begin
        // New start in the sweep_done cycle.
        m = 8'($urandom_range(255, 1));
        launch(m, 1'b1, $urandom_range(2, 0), $urandom_range(3, 0));
      end
    end
    step();
  endtask

  initial begin
    test_reset();
    test_full_sweep();
    test_sparse_continuous();
    test_stop();
    test_async_reset();
    test_mask_edges();
    test_random_scan();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
